// File: rtl/sr_tg_burst.sv
// Burst traffic generator: feeds SR core results to MIG as write bursts, reads them back and checks.
// Writes fire on full handshake; read data is compared in order against a local copy of the burst.
module sr_tg_burst #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_ADDR_WIDTH = 33,
  parameter int BURST_LEN = 16,
  parameter int NUM_BURSTS = 64,
  parameter int ADDR_STEP = 8,
  parameter int DRAIN_TIMEOUT = 512,
  parameter logic [APP_DATA_WIDTH-1:0] SEED = 64'h1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init_calib_complete,
  input  logic [APP_ADDR_WIDTH-1:0]   start_addr,
  output logic [APP_DATA_WIDTH-1:0]   sr_din,
  output logic                        sr_newd,
  input  logic                        sr_done,
  input  logic [APP_DATA_WIDTH-1:0]   sr_dout,
  input  logic                        app_rdy,
  input  logic                        app_wdf_rdy,
  input  logic                        app_rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  output logic [2:0]                  app_cmd,
  output logic [APP_ADDR_WIDTH-1:0]   app_addr,
  output logic                        app_en,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        done,
  output logic                        sim_status,
  output logic [15:0]                 err_cnt
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BW = $clog2(NUM_BURSTS + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] FULL_BEAT  = CW'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [APP_ADDR_WIDTH-1:0] base;
  logic [CW-1:0]             wcnt, rcnt, ret_idx, beat;
  logic [BW-1:0]             burst_idx;
  logic [TW-1:0]             timer;
  logic [APP_DATA_WIDTH-1:0] wbuf [BURST_LEN];
  logic [APP_ADDR_WIDTH-1:0] beat_num;
  logic fire_w, fire_r, rd_take, mismatch, drain_end, timeout, burst_exit;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_nxt;

  assign fire_w     = (state == S_WRITE) && app_rdy && app_wdf_rdy && sr_done;
  assign fire_r     = (state == S_READ) && app_rdy;
  // Returns beyond the expected count (late data after a timeout) are not compared.
  assign rd_take    = app_rd_data_valid && (ret_idx != FULL_BEAT) &&
                      ((state == S_WRITE) || (state == S_READ) || (state == S_DRAIN));
  assign mismatch   = rd_take && (app_rd_data != wbuf[ret_idx[IW-1:0]]);
  assign drain_end  = (state == S_DRAIN) && (ret_idx == FULL_BEAT);
  assign timeout    = (state == S_DRAIN) && !drain_end && (timer == TMO_LAST);
  assign burst_exit = drain_end || timeout;

  assign err_inc = {1'b0, mismatch} + {1'b0, timeout};
  assign err_sum = {1'b0, err_cnt} + 17'(err_inc);
  assign err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  assign beat     = (state == S_READ) ? rcnt : wcnt;
  assign beat_num = APP_ADDR_WIDTH'(burst_idx) * APP_ADDR_WIDTH'(BURST_LEN) + APP_ADDR_WIDTH'(beat);

  always_comb begin
    app_addr     = '0;
    app_en       = fire_w || (state == S_READ);
    app_cmd      = (state == S_WRITE) ? 3'd0 : 3'd1;
    app_wdf_data = (state == S_WRITE) ? sr_dout : '0;
    app_wdf_wren = fire_w;
    app_wdf_end  = fire_w;
    app_wdf_mask = '0;
    sr_newd      = (state == S_WRITE);
    done         = (state == S_DONE);
    sim_status   = done && (err_cnt == 16'd0);
    if (state != S_IDLE) app_addr = base + beat_num * APP_ADDR_WIDTH'(ADDR_STEP);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_WRITE;
      S_WRITE: if (fire_w && (wcnt == LAST_BEAT)) state_nxt = S_READ;
      S_READ:  if (fire_r && (rcnt == LAST_BEAT)) state_nxt = S_DRAIN;
      S_DRAIN: if (burst_exit) state_nxt = (burst_idx == LAST_BURST) ? S_DONE : S_WRITE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (!init_calib_complete) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0; wcnt <= '0; rcnt <= '0; ret_idx <= '0;
      burst_idx <= '0; timer <= '0; err_cnt <= '0; sr_din <= SEED;
    end else if (!init_calib_complete) begin
      base <= '0; wcnt <= '0; rcnt <= '0; ret_idx <= '0;
      burst_idx <= '0; timer <= '0; err_cnt <= '0; sr_din <= SEED;
    end else begin
      err_cnt <= err_nxt;
      if (rd_take) begin
        ret_idx <= ret_idx + 1'b1;
        sr_din  <= app_rd_data;
      end
      case (state)
        S_IDLE:  base <= start_addr;
        S_WRITE: begin
          if (fire_w) wcnt <= wcnt + 1'b1;
          if (fire_w && (wcnt == LAST_BEAT)) rcnt <= '0;
        end
        S_READ: begin
          if (fire_r) rcnt <= rcnt + 1'b1;
          timer <= '0;
        end
        S_DRAIN: begin
          timer <= timer + 1'b1;
          if (burst_exit) begin
            timer <= '0;
            if (burst_idx != LAST_BURST) begin
              burst_idx <= burst_idx + 1'b1;
              wcnt      <= '0;
              ret_idx   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Burst copy needs no reset: it is always rewritten before being compared.
  always_ff @(posedge clk) begin
    if (fire_w) wbuf[wcnt[IW-1:0]] <= sr_dout;
  end
endmodule

// File: tb/tb_sr_tg_burst.sv
// Directed bench for sr_tg_burst with a MIG-like memory model and an SR core stand-in.
module tb_sr_tg_burst;
  localparam int DW = 64;
  localparam int AW = 33;

  logic clk = 1'b0;
  logic rst, init_calib_complete;
  logic [AW-1:0] start_addr, app_addr;
  logic [DW-1:0] sr_din, sr_dout, app_rd_data, app_wdf_data;
  logic sr_newd, sr_done, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [2:0] app_cmd;
  logic app_en, app_wdf_wren, app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic done, sim_status;
  logic [15:0] err_cnt;

  sr_tg_burst #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .BURST_LEN(4), .NUM_BURSTS(2),
                .ADDR_STEP(8), .DRAIN_TIMEOUT(32), .SEED(64'h1)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .start_addr(start_addr),
    .sr_din(sr_din), .sr_newd(sr_newd), .sr_done(sr_done), .sr_dout(sr_dout),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .app_cmd(app_cmd), .app_addr(app_addr), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .done(done), .sim_status(sim_status), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_log[$];
  logic [AW-1:0] rd_log[$];
  logic [DW-1:0] wdata_log[$];
  logic [AW-1:0] model_a;
  int rd_ret, corrupt_idx, drop_from, stall_viol, gen;
  bit stall_on;
  int n_chk = 0;
  int n_fail = 0;

  // Inputs change on the falling edge; the accept that the next rising edge will see is sampled 1 later.
  always @(negedge clk) begin
    gen++;
    sr_dout     = {32'hC0DE0000 + 32'(gen), 32'(gen * 7)};
    sr_done     = 1'b1;
    app_rdy     = 1'b1;
    app_wdf_rdy = !stall_on;
    if (rst || !init_calib_complete) begin
      rd_q.delete();
      app_rd_data_valid = 1'b0;
      app_rd_data = '0;
    end else if (rd_q.size() > 0) begin
      model_a = rd_q.pop_front();
      app_rd_data = mem.exists(model_a) ? mem[model_a] : '0;
      if (rd_ret == corrupt_idx) app_rd_data = app_rd_data ^ 64'h1;
      app_rd_data_valid = 1'b1;
      rd_ret++;
    end else begin
      app_rd_data_valid = 1'b0;
    end
    #1;
    if (!app_wdf_rdy && (app_wdf_wren || (app_en && app_cmd == 3'd0))) stall_viol++;
    if (app_en && app_rdy) begin
      if (app_cmd == 3'd0) begin
        mem[app_addr] = app_wdf_data;
        wr_log.push_back(app_addr);
        wdata_log.push_back(app_wdf_data);
      end else begin
        rd_log.push_back(app_addr);
        if (rd_log.size() <= drop_from) rd_q.push_back(app_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; init_calib_complete = 1'b0; stall_on = 1'b0;
    corrupt_idx = -1; drop_from = 1 << 30;
    repeat (3) @(negedge clk);
    wr_log.delete(); rd_log.delete(); wdata_log.delete(); mem.delete();
    rd_ret = 0; stall_viol = 0;
    rst = 1'b0;
    @(negedge clk);
    init_calib_complete = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  // Both logs must hold 8 beats: (start + 8*i) mod 2^33.
  task automatic chk_seq(input string tag, input logic [AW-1:0] start, input bit is_rd);
    logic [AW-1:0] e;
    int sz;
    sz = is_rd ? rd_log.size() : wr_log.size();
    chk({tag, "_count"}, 64'(sz), 64'd8);
    for (int i = 0; i < 8 && i < sz; i++) begin
      e = start + AW'(i * 8);
      chk($sformatf("%s[%0d]", tag, i), 64'(is_rd ? rd_log[i] : wr_log[i]), 64'(e));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    rst = 1'b1; init_calib_complete = 1'b0; start_addr = 33'h100;
    stall_on = 1'b0; corrupt_idx = -1; drop_from = 1 << 30;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_app_en", 64'(app_en), 64'd0);
    chk("rst_app_cmd", 64'(app_cmd), 64'd1);
    chk("rst_sr_newd", 64'(sr_newd), 64'd0);
    chk("rst_sr_din", sr_din, 64'h1);
    chk("rst_app_addr", 64'(app_addr), 64'd0);
    chk("rst_wdf", {app_wdf_data[62:0], app_wdf_wren}, 64'd0);
    chk("rst_done_stat", {62'd0, done, sim_status}, 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);

    // Ideal memory, two bursts from 0x100.
    start_addr = 33'h100;
    do_reset();
    wait_done(400);
    chk_seq("basic_wr", 33'h100, 1'b0);
    chk_seq("basic_rd", 33'h100, 1'b1);
    chk("basic_err", 64'(err_cnt), 64'd0);
    chk("basic_status", 64'(sim_status), 64'd1);
    chk("basic_done_en", {62'd0, app_en, sr_newd}, 64'd0);
    chk("basic_sr_din", sr_din, wdata_log[$]);

    // Corrupted read beat 2 of burst 0.
    do_reset();
    corrupt_idx = 2;
    wait_done(400);
    chk("corrupt_err", 64'(err_cnt), 64'd1);
    chk("corrupt_status", 64'(sim_status), 64'd0);

    // Write data path stalled for 10 cycles mid-burst.
    do_reset();
    n = 0;
    while (wr_log.size() < 2 && n < 100) begin @(negedge clk); #2; n++; end
    chk("stall_reach", 64'(wr_log.size() >= 2), 64'd1);
    stall_on = 1'b1;
    n0 = wr_log.size();
    repeat (10) @(negedge clk);
    #2;
    chk("stall_no_write", 64'(wr_log.size()), 64'(n0));
    stall_on = 1'b0;
    wait_done(400);
    chk("stall_viol", 64'(stall_viol), 64'd0);
    chk_seq("stall_wr", 33'h100, 1'b0);
    chk("stall_err", 64'(err_cnt), 64'd0);

    // All read data of burst 1 lost: drain timeout.
    do_reset();
    drop_from = 4;
    wait_done(600);
    chk("drop_err", 64'(err_cnt), 64'd1);
    chk("drop_rd_issued", 64'(rd_log.size()), 64'd8);
    chk("drop_status", 64'(sim_status), 64'd0);

    // Address wrap at the top of the 33-bit space.
    start_addr = 33'h1_FFFF_FFF0;
    do_reset();
    wait_done(400);
    chk("wrap_wr0", 64'(wr_log[0]), 64'h1_FFFF_FFF0);
    chk("wrap_wr1", 64'(wr_log[1]), 64'h1_FFFF_FFF8);
    chk("wrap_wr2", 64'(wr_log[2]), 64'h0);
    chk("wrap_wr7", 64'(wr_log[7]), 64'h28);
    chk("wrap_rd2", 64'(rd_log[2]), 64'h0);
    chk("wrap_err", 64'(err_cnt), 64'd0);

    // Calibration lost during READ, then regained.
    start_addr = 33'h200;
    do_reset();
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!(app_en && app_cmd == 3'd1) && n < 100);
    chk("calib_read_seen", 64'(app_en && app_cmd == 3'd1), 64'd1);
    init_calib_complete = 1'b0;
    @(posedge clk);
    #1;
    chk("calib_app_en", 64'(app_en), 64'd0);
    chk("calib_app_addr", 64'(app_addr), 64'd0);
    chk("calib_sr_din", sr_din, 64'h1);
    chk("calib_newd", 64'(sr_newd), 64'd0);
    @(negedge clk);
    #2;
    wr_log.delete(); rd_log.delete(); wdata_log.delete(); rd_ret = 0;
    @(negedge clk);
    init_calib_complete = 1'b1;
    wait_done(400);
    chk_seq("restart_wr", 33'h200, 1'b0);
    chk_seq("restart_rd", 33'h200, 1'b1);
    chk("restart_status", 64'(sim_status), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
